// File: rtl/sntc_ldpc_pkg.sv
// Shared state/fail-cause types and width helper for the LDPC iteration controller.
package sntc_ldpc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_EVAL,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE  = 2'b00,
      FC_LOOP  = 2'b01,
      FC_STALL = 2'b10,
      FC_TMO   = 2'b11
   } fail_t;

   function automatic int sum_w(input int mm);
      return $clog2(mm + 1);
   endfunction

endpackage

// File: rtl/sntc_ldpc_best_capture.sv
// Holds the lowest syndrome distance seen in a decode run and its codeword.
module sntc_ldpc_best_capture
   import sntc_ldpc_pkg::*;
#(
   parameter int NN     = 'h000d0,
   parameter int SUM_MM = sum_w('h000a8)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clear,
   input  logic              load,
   input  logic [SUM_MM-1:0] hd,
   input  logic [NN-1:0]     y,
   output logic [SUM_MM-1:0] best_hd,
   output logic [NN-1:0]     final_y,
   output logic              improved
);

   logic [SUM_MM-1:0] best_hd_reg;
   logic [NN-1:0]     final_y_reg;

   // Strict compare: an equal distance keeps the earlier codeword.
   assign improved = (hd < best_hd_reg);

   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         best_hd_reg <= '1;
         final_y_reg <= '0;
      end else if (load && improved) begin
         best_hd_reg <= hd;
         final_y_reg <= y;
      end
   end

   assign best_hd = best_hd_reg;
   assign final_y = final_y_reg;

endmodule

// File: rtl/sntc_ldpc_iter_ctrl.sv
// LDPC decode iteration sequencer: launches iterations, tracks the best codeword
// and stops on zero syndrome, loop limit, stall or per-iteration timeout.
module sntc_ldpc_iter_ctrl
   import sntc_ldpc_pkg::*;
#(
   parameter int NN      = 'h000d0,
   parameter int MM      = 'h000a8,
   parameter int SUM_MM  = sum_w(MM),
   parameter int LOOP_W  = 8,
   parameter int STALL_W = 4,
   parameter int TMO_CYC = 1024
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               clr,
   input  logic               start_dec,
   input  logic [LOOP_W-1:0]  loop_max,
   input  logic [STALL_W-1:0] stall_max,
   output logic               iter_start,
   input  logic               iter_done,
   input  logic [SUM_MM-1:0]  iter_hd,
   input  logic [NN-1:0]      iter_y,
   output logic [NN-1:0]      final_y,
   output logic [SUM_MM-1:0]  best_hd,
   output logic [LOOP_W-1:0]  loop_cnt,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [1:0]         fail_cause
);

   localparam int               TMO_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   state_t             state_reg, state_next;
   logic               start_req_reg, start_req_next;
   logic [LOOP_W-1:0]  loop_cnt_reg, loop_cnt_next, loop_inc, loop_lim;
   logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next, stall_inc;
   logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
   fail_t              fail_reg, fail_next;
   logic [SUM_MM-1:0]  eval_hd_reg, eval_hd_next;
   logic [NN-1:0]      eval_y_reg, eval_y_next;
   logic               best_clear, best_load, improved;

   sntc_ldpc_best_capture #(
      .NN     (NN),
      .SUM_MM (SUM_MM)
   ) u_best (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (clr || best_clear),
      .load     (best_load),
      .hd       (eval_hd_reg),
      .y        (eval_y_reg),
      .best_hd  (best_hd),
      .final_y  (final_y),
      .improved (improved)
   );

   always_comb begin
      state_next     = state_reg;
      loop_cnt_next  = loop_cnt_reg;
      stall_cnt_next = stall_cnt_reg;
      tmo_cnt_next   = tmo_cnt_reg;
      fail_next      = fail_reg;
      eval_hd_next   = eval_hd_reg;
      eval_y_next    = eval_y_reg;
      best_clear     = 1'b0;
      best_load      = 1'b0;

      // start_dec is registered once so a new run launches two cycles after the pulse;
      // requests arriving while busy are dropped here.
      start_req_next = start_dec && (state_reg == ST_IDLE || state_reg == ST_DONE);

      loop_lim  = (loop_max == '0) ? '1 : loop_max;
      loop_inc  = (loop_cnt_reg == '1) ? loop_cnt_reg : loop_cnt_reg + 1'b1;
      stall_inc = improved ? '0 :
                  ((stall_cnt_reg == '1) ? stall_cnt_reg : stall_cnt_reg + 1'b1);

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start_req_reg) begin
               loop_cnt_next  = '0;
               stall_cnt_next = '0;
               fail_next      = FC_NONE;
               best_clear     = 1'b1;
               state_next     = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            tmo_cnt_next = '0;
            state_next   = ST_WAIT;
         end
         ST_WAIT: begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
            if (iter_done) begin
               eval_hd_next = iter_hd;
               eval_y_next  = iter_y;
               state_next   = ST_EVAL;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               fail_next  = FC_TMO;
               state_next = ST_DONE;
            end
         end
         ST_EVAL: begin
            best_load      = 1'b1;
            loop_cnt_next  = loop_inc;
            stall_cnt_next = stall_inc;
            // Exit checks look at the counts as they stand after this iteration.
            if (eval_hd_reg == '0) begin
               fail_next  = FC_NONE;
               state_next = ST_DONE;
            end else if (loop_inc == loop_lim) begin
               fail_next  = FC_LOOP;
               state_next = ST_DONE;
            end else if (stall_max != '0 && stall_inc == stall_max) begin
               fail_next  = FC_STALL;
               state_next = ST_DONE;
            end else begin
               state_next = ST_LAUNCH;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         state_reg     <= ST_IDLE;
         start_req_reg <= 1'b0;
         loop_cnt_reg  <= '0;
         stall_cnt_reg <= '0;
         tmo_cnt_reg   <= '0;
         fail_reg      <= FC_NONE;
         eval_hd_reg   <= '0;
         eval_y_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         start_req_reg <= start_req_next;
         loop_cnt_reg  <= loop_cnt_next;
         stall_cnt_reg <= stall_cnt_next;
         tmo_cnt_reg   <= tmo_cnt_next;
         fail_reg      <= fail_next;
         eval_hd_reg   <= eval_hd_next;
         eval_y_reg    <= eval_y_next;
      end
   end

   assign iter_start = (state_reg == ST_LAUNCH);
   assign busy       = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT) || (state_reg == ST_EVAL);
   assign done       = (state_reg == ST_DONE);
   assign pass       = done && (best_hd == '0);
   assign loop_cnt   = loop_cnt_reg;
   assign fail_cause = fail_reg;

endmodule

// File: tb/tb_sntc_ldpc_iter_ctrl.sv
// Self-checking bench for sntc_ldpc_iter_ctrl: directed table, corner sequences, random runs.
module tb_sntc_ldpc_iter_ctrl;

   localparam int NN      = 208;
   localparam int MM      = 168;
   localparam int SUM_MM  = 8;
   localparam int LOOP_W  = 8;
   localparam int STALL_W = 4;
   localparam int TMO_CYC = 16;
   localparam int HD_ONES = 255;

   logic               clk = 1'b0;
   logic               rstn, clr, start_dec, iter_done;
   logic [LOOP_W-1:0]  loop_max;
   logic [STALL_W-1:0] stall_max;
   logic [SUM_MM-1:0]  iter_hd;
   logic [NN-1:0]      iter_y;
   logic               iter_start, busy, done, pass;
   logic [NN-1:0]      final_y;
   logic [SUM_MM-1:0]  best_hd;
   logic [LOOP_W-1:0]  loop_cnt;
   logic [1:0]         fail_cause;

   sntc_ldpc_iter_ctrl #(
      .NN      (NN),
      .MM      (MM),
      .LOOP_W  (LOOP_W),
      .STALL_W (STALL_W),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .clr        (clr),
      .start_dec  (start_dec),
      .loop_max   (loop_max),
      .stall_max  (stall_max),
      .iter_start (iter_start),
      .iter_done  (iter_done),
      .iter_hd    (iter_hd),
      .iter_y     (iter_y),
      .final_y    (final_y),
      .best_hd    (best_hd),
      .loop_cnt   (loop_cnt),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .fail_cause (fail_cause)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   int          hd_arr[256];
   logic [NN-1:0] y_arr[256];

   typedef struct {
      string name;
      int    lmax;
      int    smax;
      int    hd[4];   // iterations beyond the fourth repeat hd[3]
      int    n;
      int    cause;
      int    best;
      int    idx;
   } vec_t;

   vec_t tbl[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NN-1:0] rand_y();
      logic [223:0] t;
      for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
      return t[NN-1:0];
   endfunction

   task automatic set_vec(input int i, input string nm, input int lmax, input int smax,
                          input int h0, input int h1, input int h2, input int h3,
                          input int n, input int cause, input int best, input int idx);
      tbl[i].name  = nm;
      tbl[i].lmax  = lmax;
      tbl[i].smax  = smax;
      tbl[i].hd[0] = h0;
      tbl[i].hd[1] = h1;
      tbl[i].hd[2] = h2;
      tbl[i].hd[3] = h3;
      tbl[i].n     = n;
      tbl[i].cause = cause;
      tbl[i].best  = best;
      tbl[i].idx   = idx;
   endtask

   // Reference: walk the distance sequence applying the termination rules directly.
   function automatic void ref_model(input int lmax, input int smax,
                                     output int n, output int cause, output int best, output int idx);
      int lim;
      int stall;
      lim   = (lmax == 0) ? 255 : lmax;
      stall = 0;
      best  = HD_ONES;
      idx   = 0;
      n     = 0;
      cause = 0;
      for (int k = 0; k < 256; k++) begin
         n = k + 1;
         if (hd_arr[k] < best) begin
            best  = hd_arr[k];
            idx   = k;
            stall = 0;
         end else if (stall < 15) begin
            stall++;
         end
         if (hd_arr[k] == 0) begin cause = 0; break; end
         if (n == lim) begin cause = 1; break; end
         if (smax != 0 && stall == smax) begin cause = 2; break; end
      end
   endfunction

   task automatic start_pulse();
      start_dec = 1'b1;
      tick();
      start_dec = 1'b0;
      check("start_lat_1", iter_start, 1'b0);
      tick();
      check("start_lat_2", iter_start, 1'b1);
   endtask

   // Drives one decode run acting as the decoder core; DUT must end in DONE.
   task automatic run_dec(input string tag, input int lmax, input int smax, input int exp_n,
                          input int exp_cause, input int exp_best, input int exp_idx);
      int d;
      loop_max  = LOOP_W'(lmax);
      stall_max = STALL_W'(smax);
      start_pulse();
      check("launch_loop_cnt", loop_cnt, 0);
      check("launch_best_hd", best_hd, HD_ONES);
      for (int k = 0; k < exp_n; k++) begin
         tick();
         d = $urandom_range(0, 3);
         for (int j = 0; j < d; j++) begin
            start_dec = ($urandom_range(0, 3) == 0);
            tick();
            start_dec = 1'b0;
         end
         iter_done = 1'b1;
         iter_hd   = SUM_MM'(hd_arr[k]);
         iter_y    = y_arr[k];
         tick();
         // EVAL cycle: stray done/start must be ignored
         iter_done = $urandom_range(0, 1) == 1;
         iter_hd   = '0;
         iter_y    = rand_y();
         start_dec = $urandom_range(0, 1) == 1;
         check("eval_busy", busy, 1'b1);
         tick();
         iter_done = 1'b0;
         start_dec = 1'b0;
         if (k == exp_n - 1) check("exit_done", done, 1'b1);
         else                check("next_iter_start", iter_start, 1'b1);
      end
      check("end_busy", busy, 1'b0);
      check("end_pass", pass, exp_best == 0);
      check("end_fail_cause", fail_cause, exp_cause);
      check("end_loop_cnt", loop_cnt, exp_n);
      check("end_best_hd", best_hd, exp_best);
      check("end_final_y", final_y, y_arr[exp_idx]);
      tick();
      tick();
      check("hold_done", done, 1'b1);
      check("hold_loop_cnt", loop_cnt, exp_n);
      $display("run %s: loop_max=%0d stall_max=%0d iters=%0d cause=%0d best_hd=%0d loop_cnt=%0d",
               tag, lmax, smax, exp_n, exp_cause, exp_best, loop_cnt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cause, best, idx, k;

      set_vec(0, "converge",     10, 0, 7, 3, 0, 0,   3, 0, 0, 2);
      set_vec(1, "loop_limit",    4, 0, 9, 8, 7, 6,   4, 1, 6, 3);
      set_vec(2, "stall_tie",    10, 2, 5, 5, 6, 6,   3, 2, 5, 0);
      set_vec(3, "stall_reset",  20, 2, 9, 9, 8, 8,   5, 2, 8, 2);
      set_vec(4, "loop_one",      1, 0, 4, 4, 4, 4,   1, 1, 4, 0);
      set_vec(5, "loop_max0",     0, 0, 9, 9, 9, 9, 255, 1, 9, 0);
      set_vec(6, "zero_at_limit", 2, 0, 3, 0, 0, 0,   2, 0, 0, 1);
      set_vec(7, "zero_first",    5, 3, 0, 0, 0, 0,   1, 0, 0, 0);
      set_vec(8, "loop_over_stall", 3, 2, 5, 5, 5, 5, 3, 1, 5, 0);
      set_vec(9, "stall_one",    10, 1, 6, 7, 7, 7,   2, 2, 6, 0);

      rstn = 1'b0; clr = 1'b0; start_dec = 1'b0; iter_done = 1'b0;
      loop_max = '0; stall_max = '0; iter_hd = '0; iter_y = '0;
      tick(); tick(); tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pass", pass, 1'b0);
      check("rst_iter_start", iter_start, 1'b0);
      check("rst_loop_cnt", loop_cnt, 0);
      check("rst_best_hd", best_hd, HD_ONES);
      check("rst_final_y", final_y, 0);
      check("rst_fail_cause", fail_cause, 0);
      rstn = 1'b1;
      tick();

      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 256; i++) begin
            hd_arr[i] = tbl[t].hd[(i < 4) ? i : 3];
            y_arr[i]  = rand_y();
         end
         run_dec(tbl[t].name, tbl[t].lmax, tbl[t].smax, tbl[t].n,
                 tbl[t].cause, tbl[t].best, tbl[t].idx);
      end

      // Timeout: no iter_done after launch
      loop_max = 8'd10; stall_max = '0;
      start_pulse();
      k = 0;
      while (done !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      check("tmo_latency", k, 17);
      check("tmo_fail_cause", fail_cause, 3);
      check("tmo_loop_cnt", loop_cnt, 0);
      check("tmo_best_hd", best_hd, HD_ONES);
      check("tmo_pass", pass, 1'b0);
      $display("run timeout: cycles_to_done=%0d cause=%0d", k, fail_cause);

      // Abort: clr in WAIT, then stray iter_done in IDLE
      start_pulse();
      tick();
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_busy", busy, 1'b0);
      check("clr_done", done, 1'b0);
      check("clr_iter_start", iter_start, 1'b0);
      check("clr_fail_cause", fail_cause, 0);
      check("clr_best_hd", best_hd, HD_ONES);
      iter_done = 1'b1;
      iter_hd   = '0;
      tick();
      iter_done = 1'b0;
      tick();
      check("idle_ignore_busy", busy, 1'b0);
      check("idle_ignore_done", done, 1'b0);
      check("idle_ignore_loop", loop_cnt, 0);
      $display("run abort_clr: busy=%0d done=%0d", busy, done);

      hd_arr[0] = 4; hd_arr[1] = 3;
      y_arr[0] = rand_y(); y_arr[1] = rand_y();
      run_dec("pre_reset", 2, 0, 2, 1, 3, 1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check("rstdone_done", done, 1'b0);
      check("rstdone_busy", busy, 1'b0);
      check("rstdone_loop_cnt", loop_cnt, 0);
      check("rstdone_best_hd", best_hd, HD_ONES);
      check("rstdone_final_y", final_y, 0);
      check("rstdone_fail_cause", fail_cause, 0);
      $display("run abort_rstn: done=%0d loop_cnt=%0d", done, loop_cnt);

      // Random runs against the reference model
      for (int r = 0; r < 25; r++) begin
         int lmax, smax;
         lmax = $urandom_range(1, 12);
         smax = $urandom_range(0, 4);
         for (int i = 0; i < 256; i++) begin
            hd_arr[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30);
            y_arr[i]  = rand_y();
         end
         ref_model(lmax, smax, n, cause, best, idx);
         run_dec("random", lmax, smax, n, cause, best, idx);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
